// File: rtl/pixel_word_packer.sv
// Packs PIXWIDTH-bit pixels LSB-first into DATAWIDTH-bit words for the write-master FIFO,
// flushing a zero-padded partial word at frame end and counting the words pushed.
module pixel_word_packer #(
   parameter int PIXWIDTH  = 8,
   parameter int DATAWIDTH = 32,
   parameter int CNTWIDTH  = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 frame_end,
   input  logic                 pix_valid,
   input  logic [PIXWIDTH-1:0]  pix_data,
   output logic                 pix_ready,
   output logic                 user_write_buffer,
   output logic [DATAWIDTH-1:0] user_buffer_data,
   input  logic                 user_buffer_full,
   output logic [CNTWIDTH-1:0]  words_written,
   output logic                 flush_done
);

   localparam int LANES = DATAWIDTH / PIXWIDTH;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [LW-1:0]        lane_q, lane_d;
   logic [DATAWIDTH-1:0] pack_q, pack_d;
   logic [DATAWIDTH-1:0] out_q, out_d;
   logic                 out_valid_q, out_valid_d;
   logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
   logic                 flush_done_q, flush_done_d;

   logic out_free, wr, acc, last_lane;

   // The out register can take a new word if empty or being written this cycle.
   assign out_free  = ~out_valid_q | ~user_buffer_full;
   assign wr        = out_valid_q & ~user_buffer_full;
   assign pix_ready = (state_q == RUN) & out_free;
   assign acc       = pix_valid & pix_ready;
   assign last_lane = (lane_q == LW'(LANES - 1));

   assign user_write_buffer = wr;
   assign user_buffer_data  = out_q;
   assign words_written     = cnt_q;
   assign flush_done        = flush_done_q;

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      pack_d       = pack_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q & ~wr;
      cnt_d        = wr ? cnt_q + CNTWIDTH'(1) : cnt_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = RUN;
               lane_d  = '0;
               pack_d  = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (acc) begin
               pack_d[PIXWIDTH*int'(lane_q) +: PIXWIDTH] = pix_data;
               if (last_lane) begin
                  out_d       = pack_d;
                  out_valid_d = 1'b1;
                  pack_d      = '0;
                  lane_d      = '0;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
            if (frame_end) state_d = FLUSH;
         end
         FLUSH: begin
            if (lane_q != '0) begin
               if (out_free) begin
                  out_d       = pack_q;
                  out_valid_d = 1'b1;
                  pack_d      = '0;
                  lane_d      = '0;
               end
            end else if (!out_valid_q) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         lane_q       <= '0;
         pack_q       <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         cnt_q        <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         pack_q       <= pack_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         cnt_q        <= cnt_d;
         flush_done_q <= flush_done_d;
      end
   end

endmodule
